// File: rtl/request_latch_arbiter_if.sv
// rtl/request_latch_arbiter_if.sv - request/mask/ack and code/valid/pending/overflow bundle for request_latch_arbiter
interface request_latch_arbiter_if;
  logic [3:0] req;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       ack;
  logic [1:0] code;
  logic       valid;
  logic [3:0] pending;
  logic       overflow;

  modport master (
    output req, mask_we, mask_in, ack,
    input  code, valid, pending, overflow
  );

  modport slave (
    input  req, mask_we, mask_in, ack,
    output code, valid, pending, overflow
  );
endinterface

// File: rtl/request_latch_arbiter.sv
// rtl/request_latch_arbiter.sv - latching 4-way priority arbiter with stable code/ack handshake
// Define REQ_EDGE_DETECT_EN to latch on rising edges of req instead of levels.
module request_latch_arbiter #(
  parameter logic [3:0] MASK_RESET = 4'b1111
) (
  input logic                     clk,
  input logic                     reset,
  request_latch_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] mask;
  logic [3:0] pend_q;
  logic [1:0] code_q;
  logic       ovf_q;

  logic [3:0] set_ev;
  logic [3:0] clr;
  logic [3:0] kept;
  logic [3:0] elig_now;
  logic [3:0] elig_left;

`ifdef REQ_EDGE_DETECT_EN
  logic [3:0] req_hist;

  always_ff @(posedge clk) begin
    if (reset) req_hist <= 4'b0000;
    else       req_hist <= bus.req;
  end

  assign set_ev = bus.req & ~req_hist;
`else
  assign set_ev = bus.req;
`endif

  function automatic logic [1:0] winner(input logic [3:0] v);
    logic [1:0] w;
    w = 2'd0;
    if (v[3])      w = 2'd3;
    else if (v[2]) w = 2'd2;
    else if (v[1]) w = 2'd1;
    return w;
  endfunction

  always_comb begin
    clr = 4'b0000;
    if (state == PRESENT && bus.ack) clr = 4'b0001 << code_q;
  end

  // A set-event on a bit being cleared this cycle re-latches it without overflow.
  assign kept      = pend_q & ~clr;
  assign elig_now  = pend_q & mask;
  assign elig_left = kept & mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pend_q <= 4'b0000;
      code_q <= 2'd0;
      ovf_q  <= 1'b0;
      mask   <= MASK_RESET;
    end else begin
      pend_q <= kept | set_ev;
      ovf_q  <= |(set_ev & kept);
      if (bus.mask_we) mask <= bus.mask_in;
      case (state)
        IDLE: begin
          if (|elig_now) begin
            state  <= PRESENT;
            code_q <= winner(elig_now);
          end
        end
        PRESENT: begin
          // Code is frozen until ack; back-to-back reload keeps valid high.
          if (bus.ack) begin
            if (|elig_left) code_q <= winner(elig_left);
            else            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.code     = code_q;
  assign bus.valid    = (state == PRESENT);
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: doc/request_latch_arbiter.md
REQUEST_LATCH_ARBITER -- requirements
Module: request_latch_arbiter

Interface
REQ-001 Parameter: MASK_RESET, 4'b1111, enable-mask value loaded at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  raw request lines; bit 3 (d) highest priority, bit 0 (a) lowest.
REQ-005 mask_we  input  1  mask write strobe.
REQ-006 mask_in  input  4  new enable mask; 1 = request eligible for selection.
REQ-007 ack  input  1  consumer accepts the presented code.
REQ-008 code  output  2  index of the selected request; code[1] = out1 and code[0] = out0 of a 4:2 priority encoder.
REQ-009 valid  output  1  code is meaningful and held stable.
REQ-010 pending  output  4  latched, not-yet-acknowledged requests.
REQ-011 overflow  output  1  one-cycle pulse when a set-event hits an already pending bit.

Function
REQ-012 Set-event per bit: level mode sets the bit when req[i]=1 on a clock edge; edge mode is defined in REQ-027.
REQ-013 A pending bit SHALL clear only by an acknowledge of its index or by reset.
REQ-014 A bit is eligible when pending[i] & mask[i].
REQ-015 Selection order: d > c > b > a, giving code 3/2/1/0.
REQ-016 FSM states: IDLE (valid=0) and PRESENT (valid=1).
REQ-017 IDLE -> PRESENT on the edge where any bit is eligible, using the pending state before that edge; code is latched on that edge, so first valid appears 1 cycle after a pending bit becomes eligible.
REQ-018 In PRESENT, code SHALL stay stable until ack, even if a higher-priority request arrives or the mask changes.
REQ-019 PRESENT with ack=1: clear pending[code]; if another eligible bit remains after the clear, reload code with the next winner and stay in PRESENT with valid high and no gap; otherwise go to IDLE.
REQ-020 ack in IDLE SHALL be ignored.
REQ-021 A set-event and an ack-clear on the same bit in the same cycle: set wins, the bit stays pending, and no overflow is raised.
REQ-022 overflow pulses for exactly one cycle when a set-event hits a bit that is pending and not being cleared that cycle; level mode therefore pulses each cycle a held req stays high while pending.
REQ-023 A mask write takes effect on the next edge; masked bits stay pending and reappear when re-enabled.

Reset
REQ-024 Reset forces state=IDLE, pending=0, code=0, valid=0, overflow=0, and mask=MASK_RESET.
REQ-025 Reset asserted mid-handshake SHALL drop valid the next cycle and discard all pending requests; ack during reset is ignored.
REQ-026 With EDGE_DETECT_EN defined, reset also clears the req history register to 0, so a req already high at reset release counts as a rising edge.

Configuration
REQ-027 Macro REQ_EDGE_DETECT_EN: when defined, a set-event is a rising edge of req[i] (req[i]=1 and registered previous value 0), which adds one 4-bit history register.
REQ-028 When REQ_EDGE_DETECT_EN is undefined, the block uses level mode (REQ-012) and has no history register.

Verification
REQ-029 After reset, pulse req=4'b0010 for 1 cycle -> pending=0010 next cycle; valid=1 and code=1 the following cycle; ack -> valid=0 and pending=0.
REQ-030 req=4'b1001 simultaneously, ack held high -> code=3 then code=0 on consecutive cycles with valid continuously high; then IDLE.
REQ-031 While presenting code=1, raise req[3] -> code stays 1 until ack, then code=3.
REQ-032 mask_in=4'b0111 with pending=1000 -> valid stays 0; write mask 1111 -> valid=1 and code=3.
REQ-033 Re-assert req[2] while bit 2 is pending (unacked) -> overflow=1 for one cycle; the same set-event coincident with ack of code 2 -> bit 2 stays pending and overflow=0.
REQ-034 Assert reset while valid=1 -> next cycle valid=0, pending=0, code=0; with REQ_EDGE_DETECT_EN, a held req produces no new set-event after the first edge.
